// File: rtl/osc_readout.sv
// osc_readout -- dumps a block of samples from an oscillator-bank sample
// memory as a stream of bytes to a serial transmitter.
//
// After a START request the block reads SAMPLE_COUNT samples, one at a time.
// For each sample it drives the address, waits READ_LATENCY cycles for the
// read data, then sends the sample MSB byte first over a valid/ready byte
// handshake. A one-cycle DONE pulse marks the end of the dump.
//
// Optional feature: define OSC_READOUT_HEADER_EN to send the sync bytes
// 0xA5, 0x5A before the first sample. Without the macro the header state and
// its logic are not built.
//
// Ports:
//   CLOCK     in   single clock, rising edge
//   RESET     in   synchronous reset, active low
//   START     in   single-cycle dump request; ignored while BUSY=1
//   ADDRESS   out  [ADD_WIDTH]  sample-memory read address
//   DATA      in   [DATA_WIDTH] sample-memory read data
//   TX_DATA   out  [8]          byte offered to the transmitter
//   TX_VALID  out  TX_DATA holds a valid byte
//   TX_READY  in   transmitter accepts the byte this cycle
//   BUSY      out  dump in progress
//   DONE      out  one-cycle pulse when a dump completes
module osc_readout #(
  parameter int ADD_WIDTH    = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int SAMPLE_COUNT = 16384,
  parameter int READ_LATENCY = 3
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  START,
  output logic [ADD_WIDTH-1:0]  ADDRESS,
  input  logic [DATA_WIDTH-1:0] DATA,
  output logic [7:0]            TX_DATA,
  output logic                  TX_VALID,
  input  logic                  TX_READY,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  // One extra bit so SAMPLE_COUNT = 2^ADD_WIDTH is reachable without wrap.
  localparam int IW     = ADD_WIDTH + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(SAMPLE_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE,
`ifdef OSC_READOUT_HEADER_EN
    HEADER,
`endif
    ISSUE,
    WAIT,
    SEND,
    FINISH
  } state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [ADD_WIDTH-1:0]  addr_q, addr_d;
  logic [2:0]            lat_q, lat_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]        bleft_q, bleft_d;
  logic [7:0]            txd_q, txd_d;
  logic                  txv_q, txv_d;
  logic [DATA_WIDTH-1:0] shifted;

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      lat_q   <= '0;
      shreg_q <= '0;
      bleft_q <= '0;
      txd_q   <= '0;
      txv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      lat_q   <= lat_d;
      shreg_q <= shreg_d;
      bleft_q <= bleft_d;
      txd_q   <= txd_d;
      txv_q   <= txv_d;
    end
  end

  // TX_DATA/TX_VALID are registered and updated one byte ahead, so they
  // never depend combinationally on TX_READY and hold steady while stalled.
  // The shift register keeps the byte currently on TX_DATA in its top 8 bits.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    lat_d   = lat_q;
    shreg_d = shreg_q;
    bleft_d = bleft_q;
    txd_d   = txd_q;
    txv_d   = txv_q;
    shifted = shreg_q << 8;

    case (state_q)
      IDLE: begin
        if (START) begin
          idx_d = '0;
`ifdef OSC_READOUT_HEADER_EN
          state_d = HEADER;
          txv_d   = 1'b1;
          txd_d   = 8'hA5;
          bleft_d = BCW'(1);
`else
          state_d = ISSUE;
`endif
        end
      end
`ifdef OSC_READOUT_HEADER_EN
      HEADER: begin
        if (txv_q && TX_READY) begin
          if (bleft_q == '0) begin
            txv_d   = 1'b0;
            state_d = ISSUE;
          end else begin
            txd_d   = 8'h5A;
            bleft_d = '0;
          end
        end
      end
`endif
      ISSUE: begin
        addr_d  = idx_q[ADD_WIDTH-1:0];
        lat_d   = 3'(READ_LATENCY);
        state_d = WAIT;
      end
      WAIT: begin
        lat_d = lat_q - 3'd1;
        if (lat_q == 3'd1) begin
          shreg_d = DATA;
          txd_d   = DATA[DATA_WIDTH-1 -: 8];
          txv_d   = 1'b1;
          bleft_d = BCW'(NBYTES - 1);
          state_d = SEND;
        end
      end
      SEND: begin
        if (txv_q && TX_READY) begin
          if (bleft_q == '0) begin
            txv_d = 1'b0;
            if (idx_q < LAST_IDX) begin
              idx_d   = idx_q + IW'(1);
              state_d = ISSUE;
            end else begin
              addr_d  = '0;
              state_d = FINISH;
            end
          end else begin
            shreg_d = shifted;
            txd_d   = shifted[DATA_WIDTH-1 -: 8];
            bleft_d = bleft_q - BCW'(1);
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ADDRESS  = addr_q;
  assign TX_DATA  = txd_q;
  assign TX_VALID = txv_q;
  assign BUSY     = (state_q != IDLE) && (state_q != FINISH);
  assign DONE     = (state_q == FINISH);

endmodule

// File: tb/tb_osc_readout.sv
// Bench for osc_readout: three instances (16-bit samples with 3-cycle read
// latency, a single-sample dump, and a 2-bit-address 8-bit-sample dump)
// checked against byte sequences and cycle counts derived from the
// behavioural description.
module tb_osc_readout;

`ifdef OSC_READOUT_HEADER_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  // ---------------- instance A: 4 samples, 16 bit, latency 3
  logic        start_a, txv_a, rdy_a, busy_a, done_a;
  logic [15:0] addr_a, data_a, ha1, ha2;
  logic [7:0]  txd_a;
  always @(posedge clk) begin
    ha1 <= addr_a;
    ha2 <= ha1;
  end
  assign data_a = 16'h1000 + ha2;

  osc_readout #(.ADD_WIDTH(16), .DATA_WIDTH(16), .SAMPLE_COUNT(4), .READ_LATENCY(3)) dut_a (
    .CLOCK(clk), .RESET(rst_n), .START(start_a), .ADDRESS(addr_a), .DATA(data_a),
    .TX_DATA(txd_a), .TX_VALID(txv_a), .TX_READY(rdy_a), .BUSY(busy_a), .DONE(done_a));

  // ---------------- instance B: 1 sample of 0xBEEF
  logic        start_b, txv_b, busy_b, done_b;
  logic        rdy_b = 1'b1;
  logic [15:0] addr_b;
  logic [15:0] data_b = 16'hBEEF;
  logic [7:0]  txd_b;

  osc_readout #(.ADD_WIDTH(16), .DATA_WIDTH(16), .SAMPLE_COUNT(1), .READ_LATENCY(3)) dut_b (
    .CLOCK(clk), .RESET(rst_n), .START(start_b), .ADDRESS(addr_b), .DATA(data_b),
    .TX_DATA(txd_b), .TX_VALID(txv_b), .TX_READY(rdy_b), .BUSY(busy_b), .DONE(done_b));

  // ---------------- instance C: 2-bit address, full 4-sample space, 8 bit, latency 1
  logic        start_c, txv_c, busy_c, done_c;
  logic        rdy_c = 1'b1;
  logic [1:0]  addr_c;
  logic [7:0]  data_c, txd_c;
  logic [7:0]  mem_c [4];
  assign data_c = mem_c[addr_c];

  osc_readout #(.ADD_WIDTH(2), .DATA_WIDTH(8), .SAMPLE_COUNT(4), .READ_LATENCY(1)) dut_c (
    .CLOCK(clk), .RESET(rst_n), .START(start_c), .ADDRESS(addr_c), .DATA(data_c),
    .TX_DATA(txd_c), .TX_VALID(txv_c), .TX_READY(rdy_c), .BUSY(busy_c), .DONE(done_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- monitors (sample on the falling edge)
  logic [7:0] qa[$], qb[$], qc[$];
  logic [1:0] qc_addr[$];
  int   done_cnt_a = 0, done_cnt_b = 0, done_cnt_c = 0;
  int   done_cyc_a = 0, done_cyc_b = 0, done_cyc_c = 0;
  logic stall_a = 1'b0;
  logic [7:0] stall_d_a = 8'h00;

  always @(negedge clk) begin
    if (txv_a && rdy_a) qa.push_back(txd_a);
    if (stall_a) begin
      chk("stall_data", 32'(txd_a), 32'(stall_d_a));
      chk("stall_valid", 32'(txv_a), 32'd1);
    end
    stall_a   <= txv_a && !rdy_a;
    stall_d_a <= txd_a;
    if (done_a) begin
      done_cnt_a <= done_cnt_a + 1;
      done_cyc_a <= cyc;
    end
  end

  always @(negedge clk) begin
    if (txv_b && rdy_b) qb.push_back(txd_b);
    if (done_b) begin
      done_cnt_b <= done_cnt_b + 1;
      done_cyc_b <= cyc;
    end
  end

  always @(negedge clk) begin
    if (txv_c && rdy_c) begin
      qc.push_back(txd_c);
      qc_addr.push_back(addr_c);
    end
    if (done_c) begin
      done_cnt_c <= done_cnt_c + 1;
      done_cyc_c <= cyc;
    end
  end

  // ---------------- helpers
  int pat [4] = '{1, 0, 0, 1};
  logic [7:0] exp_q[$];

  function automatic int dcnt(input int which);
    case (which)
      0:       return done_cnt_a;
      1:       return done_cnt_b;
      default: return done_cnt_c;
    endcase
  endfunction

  function automatic int dcyc(input int which);
    case (which)
      0:       return done_cyc_a;
      1:       return done_cyc_b;
      default: return done_cyc_c;
    endcase
  endfunction

  task automatic set_start(input int which, input logic v);
    case (which)
      0:       start_a = v;
      1:       start_b = v;
      default: start_c = v;
    endcase
  endtask

  // Expected byte stream: optional sync header, then every sample MSB first.
  task automatic build_exp(input int which);
    logic [15:0] v;
    exp_q.delete();
    if (HDR != 0) begin
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h5A);
    end
    case (which)
      0: for (int i = 0; i < 4; i++) begin
        v = 16'h1000 + 16'(i);
        exp_q.push_back(v[15:8]);
        exp_q.push_back(v[7:0]);
      end
      1: begin
        exp_q.push_back(8'hBE);
        exp_q.push_back(8'hEF);
      end
      default: for (int i = 0; i < 4; i++) exp_q.push_back(mem_c[i]);
    endcase
  endtask

  task automatic cmp_bytes(input string tag, input logic [7:0] act[$], input int from);
    chk({tag, "_len"}, act.size() - from, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (from + i < act.size()) chk(tag, 32'(act[from + i]), 32'(exp_q[i]));
  endtask

  // Pulse START, then drive TX_READY by mode (0: held 1, 1: 1,0,0,1 pattern,
  // 2: random) until DONE, with a bounded cycle budget. restart_at > 0 pulses
  // START again at that cycle offset while the dump is running.
  task automatic run(input int which, input int mode, input int restart_at, output int s);
    int base;
    base = dcnt(which);
    @(posedge clk); #1;
    set_start(which, 1'b1);
    s = cyc;
    for (int k = 0; k < 500 && dcnt(which) == base; k++) begin
      @(posedge clk); #1;
      set_start(which, (cyc - s) == restart_at);
      case (mode)
        0:       rdy_a = 1'b1;
        1:       rdy_a = pat[(cyc - s) % 4] != 0;
        default: rdy_a = 1'($urandom_range(0, 1));
      endcase
    end
    set_start(which, 1'b0);
    rdy_a = 1'b1;
    chk("done_seen", dcnt(which) - base, 1);
  endtask

  // ---------------- directed sequence
  int s, base, from;

  initial begin
    for (int i = 0; i < 4; i++) mem_c[i] = 8'($urandom_range(0, 255));
    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    rdy_a = 1'b1;
    repeat (3) @(posedge clk);
    #1 start_a = 1'b1;                // START while in reset must be ignored
    @(posedge clk); #1;
    start_a = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    chk("rst_address", 32'(addr_a), 32'd0);
    chk("rst_tx_data", 32'(txd_a), 32'd0);
    chk("rst_tx_valid", 32'(txv_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    repeat (2) @(negedge clk);
    chk("start_in_reset_busy", 32'(busy_a), 32'd0);

    // Plain dump, TX_READY held high
    from = qa.size();
    base = done_cnt_a;
    run(0, 0, 0, s);
    build_exp(0);
    cmp_bytes("a_bytes", qa, from);
    chk("a_done_cycle", done_cyc_a - s, 1 + HDR + 4 * (1 + 3 + 2));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("a_done_count", done_cnt_a - base, 1);
    chk("a_addr_after", 32'(addr_a), 32'd0);
    chk("a_busy_after", 32'(busy_a), 32'd0);

    // TX_READY toggling 1,0,0,1
    from = qa.size();
    run(0, 1, 0, s);
    cmp_bytes("a_toggle_bytes", qa, from);
    chk("a_toggle_addr_after", 32'(addr_a), 32'd0);

    // START pulsed again while busy
    from = qa.size();
    base = done_cnt_a;
    run(0, 0, 8, s);
    cmp_bytes("a_restart_bytes", qa, from);
    chk("a_restart_done_cycle", done_cyc_a - s, 1 + HDR + 4 * (1 + 3 + 2));
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("a_restart_done_count", done_cnt_a - base, 1);

    // Random TX_READY back-pressure
    from = qa.size();
    run(0, 2, 0, s);
    cmp_bytes("a_random_bytes", qa, from);

    // Reset during the second sample's SEND
    base = done_cnt_a;
    @(posedge clk); #1;
    start_a = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int k = 0; k < 100 && (cyc - s) < HDR + 11; k++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("pre_reset_valid", 32'(txv_a), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_valid", 32'(txv_a), 32'd0);
    chk("post_reset_busy", 32'(busy_a), 32'd0);
    chk("post_reset_addr", 32'(addr_a), 32'd0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("reset_no_done", done_cnt_a - base, 0);
    from = qa.size();
    run(0, 0, 0, s);
    build_exp(0);
    cmp_bytes("a_after_reset_bytes", qa, from);
    chk("a_after_reset_done_cycle", done_cyc_a - s, 1 + HDR + 4 * (1 + 3 + 2));

    // Single-sample dump of 0xBEEF
    from = qb.size();
    run(1, 0, 0, s);
    build_exp(1);
    cmp_bytes("b_bytes", qb, from);
    chk("b_done_cycle", done_cyc_b - s, 1 + HDR + (1 + 3 + 2));
    chk("b_done_count", done_cnt_b, 1);

    // Full 2-bit address space: addresses 0..3, no wrap, no extra sample
    from = qc.size();
    run(2, 0, 0, s);
    build_exp(2);
    cmp_bytes("c_bytes", qc, from);
    chk("c_addr_len", qc_addr.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < qc_addr.size()) chk("c_addr_seq", 32'(qc_addr[i]), i);
    chk("c_done_cycle", done_cyc_c - s, 1 + HDR + 4 * (1 + 1 + 1));
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("c_done_count", done_cnt_c, 1);
    chk("c_addr_after", 32'(addr_c), 32'd0);
    chk("c_no_extra", qc.size() - from, HDR + 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/osc_readout.md
OSC_READOUT -- requirements
Module: osc_readout

Interface
REQ-001 The block SHALL have parameter ADD_WIDTH, default 16, the sample-memory address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, the sample width; it is a multiple of 8 and at least 8.
REQ-003 The block SHALL have parameter SAMPLE_COUNT, default 16384, the number of samples read per dump; the legal range is 1..2^ADD_WIDTH.
REQ-004 The block SHALL have parameter READ_LATENCY, default 3, the number of cycles from ADDRESS change to valid DATA; the legal range is 1..7.
REQ-005 The block SHALL have a port CLOCK, input, 1 bit: the single clock; all logic is clocked on the rising edge.
REQ-006 The block SHALL have a port RESET, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have a port START, input, 1 bit: a single-cycle request to begin a dump.
REQ-008 The block SHALL have a port ADDRESS, output, ADD_WIDTH bits: the read address to the oscillator-bank sample memory.
REQ-009 The block SHALL have a port DATA, input, DATA_WIDTH bits: the sample read back from the oscillator bank.
REQ-010 The block SHALL have a port TX_DATA, output, 8 bits: the byte offered to the serial transmitter.
REQ-011 The block SHALL have a port TX_VALID, output, 1 bit: TX_DATA holds a valid byte.
REQ-012 The block SHALL have a port TX_READY, input, 1 bit: the transmitter accepts the byte.
REQ-013 The block SHALL have a port BUSY, output, 1 bit: a dump is in progress.
REQ-014 The block SHALL have a port DONE, output, 1 bit: a one-cycle pulse when a dump completes.

Function
REQ-015 The FSM SHALL have the states IDLE, HEADER, ISSUE, WAIT, SEND and FINISH.
REQ-016 In IDLE, START=1 SHALL move the FSM to HEADER (macro defined) or ISSUE (macro undefined), set the sample index to 0, and assert BUSY from the next cycle.
REQ-017 When BUSY=1, START SHALL be ignored.
REQ-018 In ISSUE, the block SHALL drive ADDRESS equal to the sample index and load the latency counter with READ_LATENCY.
REQ-019 In WAIT, the block SHALL hold ADDRESS, decrement the latency counter each cycle, and register DATA into the shift register on the cycle the counter reaches 0, then enter SEND.
REQ-020 In SEND, the block SHALL present the sample bytes MSB byte first on TX_DATA with TX_VALID=1, for DATA_WIDTH/8 bytes in total.
REQ-021 Byte transfer SHALL occur only on a cycle with TX_VALID=1 and TX_READY=1; TX_VALID is never combinationally dependent on TX_READY.
REQ-022 While TX_VALID=1 and TX_READY=0, TX_DATA and TX_VALID SHALL stay stable.
REQ-023 After the last byte of a sample transfers: if index < SAMPLE_COUNT-1, the block SHALL increment the index and return to ISSUE; otherwise it SHALL enter FINISH.
REQ-024 FINISH SHALL last exactly one cycle, assert DONE=1, set ADDRESS to 0, and return to IDLE; BUSY drops in the same cycle.
REQ-025 With SAMPLE_COUNT=1, the block SHALL send exactly one sample followed by DONE.
REQ-026 The sample index SHALL be ADD_WIDTH+1 bits wide so SAMPLE_COUNT=2^ADD_WIDTH terminates without wrap; ADDRESS is the low ADD_WIDTH bits of the index.
REQ-027 With TX_READY held at 1, each sample SHALL take 1 + READ_LATENCY + DATA_WIDTH/8 cycles.

Reset
REQ-028 When RESET=0 at a rising edge, the block SHALL set the FSM to IDLE, ADDRESS=0, TX_DATA=0, TX_VALID=0, BUSY=0, DONE=0, and clear the index, shift register and counters.
REQ-029 Reset mid-dump SHALL abort the dump with no DONE pulse, and TX_VALID SHALL be 0 in the cycle after the reset edge.
REQ-030 A START coincident with RESET=0 SHALL be ignored.

Configuration
REQ-031 With OSC_READOUT_HEADER_EN defined, state HEADER SHALL send the sync bytes 0xA5 then 0x5A under the REQ-021/REQ-022 handshake before the first ISSUE.
REQ-032 With OSC_READOUT_HEADER_EN undefined, the HEADER state and its logic SHALL be absent and IDLE SHALL go directly to ISSUE.

Verification
REQ-033 The bench SHALL cover: SAMPLE_COUNT=4, memory model returning 0x1000+addr after 3 cycles, TX_READY=1, header off -> bytes 10 00 10 01 10 02 10 03; one DONE pulse at cycle 1+4*(1+3+2); ADDRESS=0 afterwards.
REQ-034 The bench SHALL cover: same setup with TX_READY toggling 1,0,0,1 -> identical byte sequence; TX_DATA is stable on every stalled cycle.
REQ-035 The bench SHALL cover: header on, SAMPLE_COUNT=1, DATA=0xBEEF -> bytes A5 5A BE EF, then DONE.
REQ-036 The bench SHALL cover: START pulsed again while BUSY=1 -> no restart and exactly SAMPLE_COUNT samples sent.
REQ-037 The bench SHALL cover: RESET=0 asserted during the second sample's SEND -> TX_VALID=0 and BUSY=0 the next cycle, no DONE; a fresh START then restarts from ADDRESS 0.
REQ-038 The bench SHALL cover: ADD_WIDTH=2, SAMPLE_COUNT=4 -> addresses 0,1,2,3 then DONE, with no wrap and no extra sample.
